// File: rtl/mem_wait_responder_if.sv
// mem_wait_responder_if
//   Bundles the read-request handshake, the write port and the responder
//   outputs of mem_wait_responder. Clock and reset are not part of the bundle.
//
//   Parameters: AW address width, DW data width, CW wait-count width.
//   Signals (direction as seen by the responder / slave side):
//     rd        in   read request level
//     addr      in   read address, sampled when a read is accepted
//     wait_cfg  in   wait-state count, sampled when a read is accepted
//     we        in   write enable
//     waddr     in   write address
//     wdata     in   write data
//     ws        out  wait signal, high while data is not yet ready
//     rvalid    out  one-cycle pulse, first cycle rdata is valid
//     rdata     out  read data, held until the next accepted read
//     abort     out  one-cycle pulse, read dropped before delivery
//     rd_count  out  completed-read count, saturating at 255
interface mem_wait_responder_if #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int CW = 4
);
  logic          rd;
  logic [AW-1:0] addr;
  logic [CW-1:0] wait_cfg;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          ws;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          abort;
  logic [7:0]    rd_count;

  // Upstream controller side.
  modport master (
    output rd, addr, wait_cfg, we, waddr, wdata,
    input  ws, rvalid, rdata, abort, rd_count
  );

  // Responder side.
  modport slave (
    input  rd, addr, wait_cfg, we, waddr, wdata,
    output ws, rvalid, rdata, abort, rd_count
  );
endinterface

// File: rtl/mem_wait_responder.sv
// mem_wait_responder
//   Small memory (2**AW words of DW bits) that answers read requests after a
//   programmable number of wait states. A read is accepted from IDLE when rd
//   is high; ws is raised for wait_cfg cycles, then rvalid pulses for one
//   cycle with rdata loaded from memory. Dropping rd during the wait phase
//   aborts the read with a one-cycle abort pulse. Writes go straight into the
//   memory on any edge in any state. All outputs are registered.
//
//   Ports:
//     clk    in   single clock, rising edge
//     reset  in   asynchronous active-high reset (clears state, outputs, memory)
//     bus    slave modport of mem_wait_responder_if (handshake, write port,
//            ws/rvalid/rdata/abort/rd_count outputs)
//
//   The interface instance must be built with the same AW/DW/CW values.
module mem_wait_responder #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_wait_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          ws_q, ws_d;
  logic          rvalid_q, rvalid_d;
  logic          abort_q, abort_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    rd_count_q, rd_count_d;

  logic [DW-1:0] mem_q [DEPTH];

  // Address used for the data load. A zero-wait read enters DATA on the
  // acceptance edge itself, before addr_q holds the new address, so the live
  // bus address is used from IDLE.
  logic [AW-1:0] rd_addr;
  logic          load_data;

  // ------------------------------------------------------------------
  // Next-state and registered-output logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    abort_d = 1'b0;
    rd_addr = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        rd_addr = bus.addr;
        if (bus.rd) begin
          addr_d  = bus.addr;
          cnt_d   = bus.wait_cfg;
          state_d = (bus.wait_cfg != '0) ? ST_WAIT : ST_DATA;
        end
      end

      ST_WAIT: begin
        // Dropping rd wins over the final wait cycle.
        if (!bus.rd) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        state_d = bus.rd ? ST_HOLD : ST_IDLE;
      end

      ST_HOLD: begin
        if (!bus.rd) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered versions of the state being entered.
    load_data = (state_d == ST_DATA);
    ws_d      = (state_d == ST_WAIT);
    rvalid_d  = load_data;

    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    if (load_data) begin
      // mem_q is read before this edge's write lands, so a same-edge write
      // to the same word is not returned.
      rdata_d = mem_q[rd_addr];
      if (rd_count_q != 8'hFF) begin
        rd_count_d = rd_count_q + 8'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Control and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ws_q       <= 1'b0;
      rvalid_q   <= 1'b0;
      abort_q    <= 1'b0;
      rdata_q    <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ws_q       <= ws_d;
      rvalid_q   <= rvalid_d;
      abort_q    <= abort_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
    end
  end

  // ------------------------------------------------------------------
  // Memory array: one write per cycle, cleared by reset
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.we) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.ws       = ws_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.abort    = abort_q;
  assign bus.rdata    = rdata_q;
  assign bus.rd_count = rd_count_q;

endmodule

// File: doc/mem_wait_responder.md
MEM_WAIT_RESPONDER -- requirements
Module: mem_wait_responder

Interface
REQ-001 Parameter AW, default 4, address width; memory depth SHALL be 2**AW words.
REQ-002 Parameter DW, default 8, data word width.
REQ-003 Parameter CW, default 4, wait-state count width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rd  input  1  read request level from the upstream read controller.
REQ-007 addr  input  AW  read address; sampled only when a read is accepted.
REQ-008 wait_cfg  input  CW  number of wait-state cycles; sampled only when a read is accepted.
REQ-009 we  input  1  write enable, one word per cycle.
REQ-010 waddr  input  AW  write address.
REQ-011 wdata  input  DW  write data.
REQ-012 ws  output  1  wait signal to the controller; high while data is not yet ready.
REQ-013 rvalid  output  1  one-cycle pulse marking the first cycle rdata is valid.
REQ-014 rdata  output  DW  read data; held stable from the rvalid cycle until the next accepted read.
REQ-015 abort  output  1  one-cycle pulse; rd dropped before data was delivered.
REQ-016 rd_count  output  8  count of completed reads; saturates at 255.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT, DATA and HOLD; all outputs SHALL be registered.
REQ-018 IDLE: when rd=1 at an edge, the block SHALL latch addr into addr_q and wait_cfg into cnt. It SHALL go to WAIT if wait_cfg!=0, else to DATA.
REQ-019 WAIT: ws=1 and cnt decrements each cycle; when cnt=1 at an edge, the next state SHALL be DATA. ws SHALL therefore be high for exactly wait_cfg cycles, starting the cycle after rd is sampled.
REQ-020 On the edge entering DATA:
- rdata SHALL load mem[addr_q] with its pre-edge contents; a write on that same edge is not visible.
- rd_count SHALL increment unless it is at 255.
REQ-021 DATA: rvalid=1 and ws=0 for exactly one cycle; the next state SHALL be HOLD.
- Exception: if rd=0 at that edge, the next state SHALL be IDLE.
REQ-022 HOLD: ws=0 and rvalid=0; the FSM SHALL remain in HOLD while rd=1 and go to IDLE on the first edge with rd=0.
- A new read SHALL be accepted only from IDLE, which requires rd to drop for at least one cycle.
REQ-023 rd=0 at an edge while in WAIT SHALL abort the read:
- next state IDLE, ws=0, abort=1 for one cycle;
- rdata, rvalid and rd_count unchanged.
REQ-024 Writes with we=1 SHALL update mem[waddr] on any edge, in any state.
- A write to addr_q while in WAIT SHALL be visible in the data returned, provided it occurs before the edge entering DATA.
REQ-025 addr and wait_cfg changes outside the acceptance edge SHALL have no effect on the read in progress.
REQ-026 rd_count SHALL hold at 255 once reached, with no wrap.

Reset
REQ-027 reset=1 SHALL asynchronously force:
- state IDLE;
- ws=0, rvalid=0, abort=0, rdata=0, rd_count=0, cnt=0, addr_q=0;
- all mem words to 0.
REQ-028 Reset asserted mid-read SHALL abandon the read with no rvalid or abort pulse; the first edge after release SHALL evaluate from IDLE.

Verification
REQ-029 Write mem[3]=8'hA5; then rd=1, addr=3, wait_cfg=2, rd held high -> ws high for 2 cycles starting the cycle after rd is sampled, then rvalid pulse with rdata=8'hA5, rd_count=1.
REQ-030 wait_cfg=0, addr=3 -> ws never high, rvalid one cycle after rd is sampled, rdata=8'hA5.
REQ-031 wait_cfg=5, rd dropped after the 2nd ws cycle -> abort pulse on the next cycle, ws=0, no rvalid, rd_count unchanged.
REQ-032 Write mem[3]=8'h3C during WAIT of an addr=3 read, earlier than the DATA-entry edge -> rdata=8'h3C.
REQ-033 rd held high across 3 cycles of HOLD -> no second read accepted; after rd=0 for one cycle then rd=1, the next read is accepted normally.
REQ-034 Reset asserted during WAIT -> ws=0 immediately without waiting for a clock edge, all outputs 0, mem[3]=0; 256 completed reads after release -> rd_count=255.
